// File: rtl/j1_io_if.sv
// j1 core I/O bus between the CPU (master) and an I/O responder (slave).
//   io_we  : write strobe, one cycle
//   io_re  : read strobe, one cycle
//   io_ptr : access address
//   io_out : CPU write data
//   io_in  : read data back to the CPU (combinational on the slave side)
interface j1_io_if #(parameter int WIDTH = 16);
  logic             io_we;
  logic             io_re;
  logic [WIDTH-1:0] io_ptr;
  logic [WIDTH-1:0] io_out;
  logic [WIDTH-1:0] io_in;

  modport master (output io_we, io_re, io_ptr, io_out, input io_in);
  modport slave  (input io_we, io_re, io_ptr, io_out, output io_in);
endinterface

// File: rtl/j1_io_responder.sv
// j1_io_responder: memory-mapped I/O block for the j1 core.
// Word registers at BASE+0..3: DATA (UART TX push / RX byte), STATUS,
// TICKS (free-running counter), LEDS. Read data is combinational because
// the core latches io_in at the next posedge.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   io       : j1 I/O bus (slave modport)
//   uart_rx  : serial input, asynchronous to clk
//   uart_tx  : serial output, idles high
//   leds     : LED register
// Optional: define J1_IO_LOOPBACK_EN to make STATUS[6] a loopback switch
// (RX fed from the internal TX line, uart_tx held high).
module j1_io_responder #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] BASE         = 16'h4000,
  parameter int               CLKS_PER_BIT = 217,
  parameter int               TXF_LOG2     = 2
) (
  input  logic       clk,
  input  logic       rst,
  j1_io_if.slave     io,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] leds
);
  localparam int            DEPTH    = 1 << TXF_LOG2;
  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- decode ----------------
  logic [WIDTH-1:0] off;
  logic in_win, sel_data, sel_stat, sel_led;
  logic wr_data, rd_data, wr_stat, wr_led;
  logic unused_bits;

  assign off      = io.io_ptr - BASE;
  assign in_win   = (off[WIDTH-1:2] == '0);
  assign sel_data = in_win && (off[1:0] == 2'd0);
  assign sel_stat = in_win && (off[1:0] == 2'd1);
  assign sel_led  = in_win && (off[1:0] == 2'd3);
  assign wr_data  = io.io_we && sel_data;
  assign rd_data  = io.io_re && sel_data;
  assign wr_stat  = io.io_we && sel_stat;
  assign wr_led   = io.io_we && sel_led;
  assign unused_bits = ^io.io_out;

  // ---------------- ticks / leds ----------------
  logic [WIDTH-1:0] ticks;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ticks <= '0;
      leds  <= '0;
    end else begin
      ticks <= ticks + 1'b1;
      if (wr_led) leds <= io.io_out[7:0];
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]          txf_mem [DEPTH];
  logic [TXF_LOG2-1:0] txf_wp, txf_rp;
  logic [TXF_LOG2:0]   txf_cnt;
  logic txf_full, txf_empty, txf_push, txf_pop;

  assign txf_full  = (txf_cnt == (TXF_LOG2+1)'(DEPTH));
  assign txf_empty = (txf_cnt == '0);
  assign txf_push  = wr_data && !txf_full;

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem[txf_wp] <= io.io_out[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txf_wp  <= '0;
      txf_rp  <= '0;
      txf_cnt <= '0;
    end else begin
      if (txf_push) txf_wp <= txf_wp + 1'b1;
      if (txf_pop)  txf_rp <= txf_rp + 1'b1;
      case ({txf_push, txf_pop})
        2'b10:   txf_cnt <= txf_cnt + 1'b1;
        2'b01:   txf_cnt <= txf_cnt - 1'b1;
        default: txf_cnt <= txf_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t     tx_st, tx_nx;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick, tx_line, tx_busy;

  assign tx_tick = (tx_cnt == BIT_END);
  assign tx_busy = !txf_empty || (tx_st != TX_IDLE);

  always_comb begin
    tx_nx   = tx_st;
    txf_pop = 1'b0;
    tx_line = 1'b1;
    case (tx_st)
      TX_IDLE:  if (!txf_empty) begin txf_pop = 1'b1; tx_nx = TX_START; end
      TX_START: begin tx_line = 1'b0; if (tx_tick) tx_nx = TX_DATA; end
      TX_DATA:  begin tx_line = tx_sh[0]; if (tx_tick && tx_bit == 3'd7) tx_nx = TX_STOP; end
      TX_STOP:  if (tx_tick) tx_nx = TX_IDLE;
      default:  tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= (tx_st == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_st != TX_DATA) tx_bit <= '0;
      else if (tx_tick)     tx_bit <= tx_bit + 1'b1;
      if (txf_pop)                      tx_sh <= txf_mem[txf_rp];
      else if (tx_st == TX_DATA && tx_tick) tx_sh <= {1'b0, tx_sh[7:1]};
    end
  end

  // ---------------- loopback option ----------------
  logic loopback, rx_src;
`ifdef J1_IO_LOOPBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          loopback <= 1'b0;
    else if (wr_stat) loopback <= io.io_out[6];
  end
  assign uart_tx = loopback ? 1'b1 : tx_line;
  assign rx_src  = loopback ? tx_line : uart_rx;
`else
  assign loopback = 1'b0;
  assign uart_tx  = tx_line;
  assign rx_src   = uart_rx;
`endif

  // ---------------- RX path ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t     rx_st, rx_nx;
  logic [1:0]    rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh, rx_data;
  logic          rx_s, rx_tick, rx_half, rx_done, rx_ferr_set;
  logic          rx_valid, rx_overrun, rx_frame_err, tx_drop;

  assign rx_s    = rx_sync[1];
  assign rx_tick = (rx_cnt == BIT_END);
  assign rx_half = (rx_cnt == HALF_END);

  always_comb begin
    rx_nx       = rx_st;
    rx_done     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_st)
      RX_IDLE:  if (!rx_s) rx_nx = RX_START;
      // A start bit that is gone by mid-bit is treated as a glitch.
      RX_START: if (rx_half) rx_nx = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nx = RX_STOP;
      RX_STOP:  if (rx_tick) begin
                  if (rx_s) begin rx_done = 1'b1; rx_nx = RX_IDLE; end
                  else begin rx_ferr_set = 1'b1; rx_nx = RX_WAIT; end
                end
      // Broken frame: don't re-arm until the line returns high.
      RX_WAIT:  if (rx_s) rx_nx = RX_IDLE;
      default:  rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx_src};
      rx_st   <= rx_nx;
      if (rx_nx != rx_st || rx_tick || rx_st == RX_IDLE || rx_st == RX_WAIT) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_st != RX_DATA) rx_bit <= '0;
      else if (rx_tick)     rx_bit <= rx_bit + 1'b1;
      if (rx_st == RX_DATA && rx_tick) rx_sh <= {rx_s, rx_sh[7:1]};
    end
  end

  // Holding register and sticky flags; a setting event beats a W1C clear.
  // A DATA read coinciding with a new byte leaves rx_valid set and is not
  // an overrun: the CPU consumed the old byte that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      if (rx_done) rx_data <= rx_sh;
      if (rx_done)      rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;
      rx_overrun   <= (rx_done && rx_valid && !rd_data) | (rx_overrun   & ~(wr_stat & io.io_out[3]));
      rx_frame_err <= rx_ferr_set                       | (rx_frame_err & ~(wr_stat & io.io_out[4]));
      tx_drop      <= (wr_data && txf_full)             | (tx_drop      & ~(wr_stat & io.io_out[5]));
    end
  end

  // ---------------- read mux ----------------
  logic [6:0] status;
  assign status = {loopback, tx_drop, rx_frame_err, rx_overrun, tx_busy, txf_full, rx_valid};

  always_comb begin
    io.io_in = '0;
    if (in_win) begin
      case (off[1:0])
        2'd0:    io.io_in = WIDTH'(rx_data);
        2'd1:    io.io_in = WIDTH'(status);
        2'd2:    io.io_in = ticks;
        default: io.io_in = WIDTH'(leds);
      endcase
    end
  end
endmodule

// File: tb/tb_j1_io_responder.sv
module tb_j1_io_responder;
  localparam int          CPB    = 4;
  localparam logic [15:0] A_DATA = 16'h4000;
  localparam logic [15:0] A_STAT = 16'h4001;
  localparam logic [15:0] A_TICK = 16'h4002;
  localparam logic [15:0] A_LED  = 16'h4003;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] leds;

  j1_io_if #(.WIDTH(16)) io ();

  j1_io_responder #(.WIDTH(16), .BASE(16'h4000), .CLKS_PER_BIT(CPB), .TXF_LOG2(2)) dut (
    .clk(clk), .rst(rst), .io(io), .uart_rx(uart_rx), .uart_tx(uart_tx), .leds(leds));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] ptr;
    logic [15:0] dat;
    logic [15:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample io_in mid-cycle, release after posedge.
  task automatic access(input logic we, input logic re, input logic [15:0] ptr,
                        input logic [15:0] dat, output logic [15:0] rd);
    @(negedge clk);
    io.io_we = we; io.io_re = re; io.io_ptr = ptr; io.io_out = dat;
    #1 rd = io.io_in;
    @(posedge clk); #1;
    io.io_we = 1'b0; io.io_re = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] ptr, input logic [15:0] exp);
    logic [15:0] r;
    access(1'b0, 1'b1, ptr, 16'h0, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [15:0] ptr, input logic [15:0] dat);
    logic [15:0] r;
    access(1'b1, 1'b0, ptr, dat, r);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); uart_rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk); uart_rx = 1'b1;
  endtask

  task automatic recv_tx(output logic [7:0] b);
    int n = 0;
    b = 8'h00;
    do begin @(negedge clk); n++; end while (uart_tx !== 1'b0 && n < 200);
    check("tx_frame_start", n < 200, 1'b1);
    if (n < 200) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      check("tx_stop_bit", uart_tx, 1'b1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, t1, t2;
    logic [7:0]  rb [5];
    logic [63:0] frame, expf;
    logic [9:0]  fb;
    int          n, lows;

    vecs[0]  = '{1'b0, 1'b1, A_DATA,     16'h0000, 16'h0000, "rst_data"};
    vecs[1]  = '{1'b0, 1'b1, A_STAT,     16'h0000, 16'h0000, "rst_status"};
    vecs[2]  = '{1'b0, 1'b1, A_LED,      16'h0000, 16'h0000, "rst_leds"};
    vecs[3]  = '{1'b1, 1'b0, A_LED,      16'h12A5, 16'h0000, "led_wr_old"};
    vecs[4]  = '{1'b0, 1'b1, A_LED,      16'h0000, 16'h00A5, "led_rd"};
    vecs[5]  = '{1'b0, 1'b1, 16'h4004,   16'h0000, 16'h0000, "unmapped_hi"};
    vecs[6]  = '{1'b1, 1'b0, 16'h4005,   16'hFFFF, 16'h0000, "unmapped_wr"};
    vecs[7]  = '{1'b0, 1'b1, 16'h3FFF,   16'h0000, 16'h0000, "unmapped_lo"};
    vecs[8]  = '{1'b0, 1'b1, A_LED,      16'h0000, 16'h00A5, "led_after_unmapped"};
    vecs[9]  = '{1'b1, 1'b1, A_LED,      16'h003C, 16'h00A5, "led_wr_rd_same"};
    vecs[10] = '{1'b0, 1'b1, A_LED,      16'h0000, 16'h003C, "led_rd2"};
    vecs[11] = '{1'b1, 1'b1, A_STAT,     16'h0038, 16'h0000, "stat_w1c_idle"};
    vecs[12] = '{1'b0, 1'b1, 16'hC003,   16'h0000, 16'h0000, "far_alias"};

    io.io_we = 1'b0; io.io_re = 1'b0; io.io_ptr = A_TICK; io.io_out = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ticks", io.io_in, 16'h0000);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_leds_port", leds, 8'h00);
    @(negedge clk); rst = 1'b0;

    // ---- register map vectors ----
    for (int i = 0; i < NV; i++) begin
      access(vecs[i].we, vecs[i].re, vecs[i].ptr, vecs[i].dat, r);
      check(vecs[i].name, r, vecs[i].exp);
    end
    check("leds_port", leds, 8'h3C);

    // ---- ticks advance one per clock ----
    access(1'b0, 1'b1, A_TICK, 16'h0, t1);
    repeat (9) @(posedge clk);
    access(1'b0, 1'b1, A_TICK, 16'h0, t2);
    check("ticks_delta", t2 - t1, 16'd10);

    // ---- single TX byte 0x55, exact bit widths ----
    wr(A_DATA, 16'h0055);
    rd_chk("tx_busy_start", A_STAT, 16'h0004);
    n = 0;
    do begin @(negedge clk); n++; end while (uart_tx !== 1'b0 && n < 20);
    check("tx55_start", n < 20, 1'b1);
    fb = {1'b1, 8'h55, 1'b0};
    frame = '0; expf = '0;
    frame[0] = uart_tx; expf[0] = fb[0];
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      frame[k] = uart_tx;
      expf[k]  = fb[k / CPB];
    end
    check("tx55_waveform", frame, expf);
    rd_chk("tx_busy_done", A_STAT, 16'h0000);

    // ---- back-to-back bytes, FIFO full and drop ----
    fork
      begin
        for (int i = 1; i <= 6; i++) wr(A_DATA, 16'(i));
        rd_chk("txf_full_drop", A_STAT, 16'h0026);
      end
      begin
        for (int i = 0; i < 5; i++) recv_tx(rb[i]);
      end
    join
    for (int i = 0; i < 5; i++) check("tx_b2b_byte", rb[i], 8'(i + 1));
    lows = 0;
    repeat (60) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    check("tx_no_dropped_byte", lows, 0);
    rd_chk("tx_drop_sticky", A_STAT, 16'h0020);
    wr(A_STAT, 16'h0020);
    rd_chk("tx_drop_cleared", A_STAT, 16'h0000);

    // ---- RX good byte, read clears valid ----
    send_rx(8'hA3, 1'b1);
    repeat (3) @(negedge clk);
    rd_chk("rx_valid", A_STAT, 16'h0001);
    rd_chk("rx_data_a3", A_DATA, 16'h00A3);
    rd_chk("rx_valid_cleared", A_STAT, 16'h0000);

    // ---- RX overrun ----
    send_rx(8'h11, 1'b1);
    send_rx(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    rd_chk("rx_overrun", A_STAT, 16'h0009);
    rd_chk("rx_data_3c", A_DATA, 16'h003C);
    rd_chk("rx_overrun_sticky", A_STAT, 16'h0008);
    wr(A_STAT, 16'h0008);
    rd_chk("rx_overrun_cleared", A_STAT, 16'h0000);

    // ---- RX framing error ----
    send_rx(8'hF0, 1'b0);
    repeat (4) @(negedge clk);
    rd_chk("rx_frame_err", A_STAT, 16'h0010);
    rd_chk("rx_data_kept_ferr", A_DATA, 16'h003C);
    wr(A_STAT, 16'h0010);
    rd_chk("rx_ferr_cleared", A_STAT, 16'h0000);

    // ---- RX one-cycle glitch ----
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("rx_glitch_status", A_STAT, 16'h0000);
    rd_chk("rx_glitch_data", A_DATA, 16'h003C);

`ifdef J1_IO_LOOPBACK_EN
    // ---- internal loopback ----
    wr(A_STAT, 16'h0040);
    rd_chk("lb_on", A_STAT, 16'h0040);
    wr(A_DATA, 16'h007E);
    lows = 0;
    repeat (70) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    check("lb_tx_held_high", lows, 0);
    rd_chk("lb_rx_valid", A_STAT, 16'h0041);
    rd_chk("lb_rx_data", A_DATA, 16'h007E);
    wr(A_STAT, 16'h0000);
    rd_chk("lb_off", A_STAT, 16'h0000);
`else
    wr(A_STAT, 16'h0040);
    rd_chk("lb_absent", A_STAT, 16'h0000);
`endif

    // ---- reset in the middle of a TX frame ----
    wr(A_DATA, 16'h0000);
    n = 0;
    do begin @(negedge clk); n++; end while (uart_tx !== 1'b0 && n < 20);
    check("rst_mid_start", n < 20, 1'b1);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_uart_tx", uart_tx, 1'b1);
    @(negedge clk); rst = 1'b0;
    rd_chk("rst_mid_status", A_STAT, 16'h0000);
    rd_chk("rst_mid_leds", A_LED, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/j1_io_responder.md
Name: j1_io_responder

Overview:
- Memory-mapped I/O responder on the far side of the j1 core's I/O bus (io_we/io_re/io_ptr/io_out/io_in).
- Decodes CPU I/O accesses into a UART transmitter with a small TX FIFO, a UART receiver with a one-byte holding register, a free-running tick counter, and an LED register.
- Returns read data combinationally in the same cycle, because the core latches io_in at the next posedge.

Parameters:
- WIDTH, 16, bus data/address width; matches core `WIDTH.
- BASE, 16'h4000, base address of the register window; must have bit 15 or 14 set so the core asserts io_re.
- CLKS_PER_BIT, 217, clock cycles per UART bit; minimum 4.
- TXF_LOG2, 2, log2 of TX FIFO depth; default depth is 4.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- io_we  in  1  CPU write strobe, valid for one cycle.
- io_re  in  1  CPU read strobe, valid for one cycle.
- io_ptr  in  WIDTH  access address.
- io_out  in  WIDTH  CPU write data.
- io_in  out  WIDTH  read data to CPU, combinational.
- uart_rx  in  1  serial input, asynchronous to clk.
- uart_tx  out  1  serial output, idles high.
- leds  out  8  LED register.

Behaviour:
- Register map (word addresses relative to BASE; all others read 0, writes ignored):
  - +0 DATA. Write pushes io_out[7:0] into TX FIFO. Read returns {8'h00, rx_data}.
  - +1 STATUS, read bits:
    - [0] rx_valid
    - [1] txf_full
    - [2] tx_busy (FIFO non-empty or shifter active)
    - [3] rx_overrun, sticky
    - [4] rx_frame_err, sticky
    - [5] tx_drop, sticky
    - [6] loopback
    - other bits 0
  - +1 STATUS write: bits [5:3] written 1 clear the matching sticky flag (W1C); bit [6] writes loopback.
  - +2 TICKS: read-only WIDTH-bit counter, increments every clk, wraps at 2**WIDTH-1 -> 0.
  - +3 LEDS: read/write; io_out[7:0] -> leds; read returns {8'h00, leds}.
- Reset values:
  - uart_tx=1, leds=0, ticks=0.
  - FIFO empty; rx_valid, rx_data, all sticky flags and loopback = 0.
  - Both FSMs IDLE; io_in follows its decode (0 unless an address is selected).
- Read side effects at posedge with io_re=1 and DATA selected: rx_valid cleared.
- TX FIFO:
  - Push when a DATA write occurs and FIFO is not full.
  - Write while full: byte dropped, tx_drop set, FIFO unchanged.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - Pointers wrap modulo depth.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: pop the FIFO head when non-empty; enter START the next cycle.
  - Each state holds CLKS_PER_BIT cycles.
  - DATA sends 8 bits LSB first; STOP drives 1.
  - Back-to-back bytes: STOP -> START directly (via IDLE pop) with no extra idle bit beyond one cycle.
  - Bytes pushed while busy are queued.
- RX path:
  - 2-flop synchronizer on the input.
  - IDLE: wait for a falling edge, then wait CLKS_PER_BIT/2 and resample.
  - Resample high: glitch, return to IDLE with no flag.
  - Otherwise sample 8 bits at bit centers (every CLKS_PER_BIT), then the stop bit.
  - Stop=1: load rx_data and set rx_valid; if rx_valid was already 1, also set rx_overrun (new byte overwrites).
  - Stop=0: byte discarded, rx_frame_err set; wait for the line to go high before IDLE.
- Simultaneous DATA read and RX byte completion in one cycle:
  - New byte loaded, rx_valid stays 1, no overrun.
  - io_in that cycle shows the old byte.
- Simultaneous sticky W1C and setting event: set wins.
- io_we and io_re both high in one cycle: both honoured independently.
- Reset mid-frame: uart_tx returns high immediately; the partial RX byte is lost.

Optional Feature:
- Macro J1_IO_LOOPBACK_EN.
- Defined: STATUS[6] is writable. When 1, the RX synchronizer input is the internal TX line instead of uart_rx, and uart_tx is held at 1.
- Undefined: STATUS[6] reads 0, writes to it are ignored, and RX always uses uart_rx.

Test Plan:
- Reset, then read +0..+3 -> DATA=0, STATUS=0x0000, LEDS=0. TICKS read N cycles after reset equals N-1 (counts from 0).
- CLKS_PER_BIT=4, write 0x55 to DATA -> uart_tx shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles wide. STATUS[2] is 1 during the frame and 0 after the stop bit.
- Write 6 bytes 0x01..0x06 back-to-back with depth 4 -> one byte in the shifter, the FIFO fills, STATUS[1]=1, tx_drop=1. uart_tx carries 0x01..0x05. Write 0x20 to STATUS -> tx_drop=0.
- Drive 0xA3 on uart_rx at 4 clk/bit -> STATUS[0]=1, DATA read returns 0x00A3, the next STATUS[0]=0. A second byte 0x3C sent before reading sets STATUS[3].
- Drive a frame with stop bit 0 -> rx_valid stays 0, STATUS[4]=1. A 1-cycle low glitch on uart_rx -> no flag, no data.
- With J1_IO_LOOPBACK_EN: write 0x40 to STATUS, then 0x7E to DATA -> rx_data=0x7E, rx_valid=1, uart_tx constant 1.
